// File: rtl/snn_pkg.sv
// Types and helpers shared by the spiking-network controller and its input-side blocks.
package snn_pkg;

  localparam int SR_DEPTH_DEF = 16384;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int IDXW = idx_width(SR_DEPTH_DEF);

  typedef struct packed {
    logic [IDXW-1:0] index;
  } spike_event_t;

  // Controller states, kept here so the controller and its feeders agree on one definition.
  typedef enum logic [1:0] {
    C_IDLE,
    C_PROC,
    C_ACCU
  } c_state;

endpackage

// File: rtl/spike_event_fifo.sv
// Synchronous event FIFO with push/pop/flush and an occupancy count; the head output is masked to zero when empty.
module spike_event_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 14
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic                     head_valid,
  output logic [W-1:0]             head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full       = (count == (AW+1)'(DEPTH));
  assign head_valid = (count != '0);
  assign do_push    = push && !full;
  assign do_pop     = pop && head_valid;
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push && !reset && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/spike_event_arbiter.sv
// Round-robin arbitration of several spike sources into one buffered event stream for the network controller.
module spike_event_arbiter
  import snn_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int SR_DEPTH   = SR_DEPTH_DEF,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  flush,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ*idx_width(SR_DEPTH)-1:0] req_index,
  output logic [NUM_REQ-1:0]                    req_ready,
  output logic                                  input_occurred,
  output logic [idx_width(SR_DEPTH)-1:0]        input_index,
  input  logic                                  input_ack,
  output logic [$clog2(FIFO_DEPTH):0]           fifo_count,
  output logic [15:0]                           accepted_count
);

  localparam int IW = idx_width(SR_DEPTH);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] grant_idx;
  logic          grant_any;
  logic          full;
  logic [IW-1:0] grant_data;
  int            cand;

  // Search from rr_ptr upward (mod NUM_REQ); the first pending requester wins.
  always_comb begin
    req_ready = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    if (!reset && !flush && !full) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand = (int'(rr_ptr) + i) % NUM_REQ;
        if (!grant_any && req_valid[cand]) begin
          grant_any       = 1'b1;
          grant_idx       = PW'(cand);
          req_ready[cand] = 1'b1;
        end
      end
    end
  end

  assign grant_data = req_index[int'(grant_idx)*IW +: IW];

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr         <= '0;
      accepted_count <= '0;
    end else if (grant_any) begin
      rr_ptr         <= PW'((int'(grant_idx) + 1) % NUM_REQ);
      accepted_count <= accepted_count + 16'd1;
    end
  end

  spike_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (IW)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push       (grant_any),
    .push_data  (grant_data),
    .pop        (input_ack),
    .head_valid (input_occurred),
    .head_data  (input_index),
    .count      (fifo_count),
    .full       (full)
  );

endmodule

// File: tb/tb_spike_event_arbiter.sv
// Bench for spike_event_arbiter: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_spike_event_arbiter;

  localparam int NR = 4;
  localparam int IW = 14;
  localparam int FD = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           flush;
  logic [NR-1:0]  req_valid;
  logic [NR*IW-1:0] req_index;
  logic [NR-1:0]  req_ready;
  logic           input_occurred;
  logic [IW-1:0]  input_index;
  logic           input_ack;
  logic [3:0]     fifo_count;
  logic [15:0]    accepted_count;

  int checks   = 0;
  int failures = 0;

  logic [IW-1:0] mq[$];
  int            m_rr;
  logic [15:0]   m_acc;

  spike_event_arbiter #(.NUM_REQ(NR), .SR_DEPTH(16384), .FIFO_DEPTH(FD)) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .req_valid      (req_valid),
    .req_index      (req_index),
    .req_ready      (req_ready),
    .input_occurred (input_occurred),
    .input_index    (input_index),
    .input_ack      (input_ack),
    .fifo_count     (fifo_count),
    .accepted_count (accepted_count)
  );

  always #5 clk = ~clk;

  // Which requester the rules say gets the slot this cycle (one-hot, or zero).
  function automatic logic [NR-1:0] m_grant();
    logic [NR-1:0] g;
    g = '0;
    if (!reset && !flush && mq.size() < FD) begin
      for (int k = 0; k < NR; k++) begin
        if (g == '0 && req_valid[(m_rr + k) % NR]) g[(m_rr + k) % NR] = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [34:0] exp_out();
    logic [IW-1:0] h;
    h = (mq.size() != 0) ? mq[0] : '0;
    return {mq.size() != 0, h, 4'(mq.size()), m_acc};
  endfunction

  task automatic m_tick(input logic [NR-1:0] g);
    if (reset) begin
      mq.delete();
      m_rr  = 0;
      m_acc = '0;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (input_ack && mq.size() != 0) void'(mq.pop_front());
      for (int r = 0; r < NR; r++) begin
        if (g[r]) begin
          mq.push_back(req_index[r*IW +: IW]);
          m_rr  = (r + 1) % NR;
          m_acc = m_acc + 16'd1;
        end
      end
    end
  endtask

  task automatic tick();
    logic [NR-1:0] g;
    g = m_grant();
    @(posedge clk);
    #1;
    m_tick(g);
  endtask

  task automatic set_idx(input int r, input int v);
    req_index[r*IW +: IW] = IW'(v);
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; input_ack = 1'b0; req_valid = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; input_ack = 1'b0; req_valid = 4'hF; req_index = '0;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready);
    end
    tick(); tick();
    checks++;
    if ({input_occurred, input_index, fifo_count, accepted_count} !== 35'd0) begin
      failures++; $display("FAIL reset_outputs occ=%b idx=%0d cnt=%0d acc=%0d exp all zero",
                           input_occurred, input_index, fifo_count, accepted_count);
    end
    reset = 1'b0; req_valid = '0;
  endtask

  task automatic test_single();
    do_reset();
    set_idx(0, 100); req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++; $display("FAIL single_grant got=%b exp=0001", req_ready);
    end
    tick(); req_valid = '0; #1;
    checks++;
    if ({input_occurred, input_index, fifo_count} !== {1'b1, 14'd100, 4'd1}) begin
      failures++; $display("FAIL single_head occ=%b idx=%0d cnt=%0d exp 1/100/1",
                           input_occurred, input_index, fifo_count);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (input_occurred !== 1'b1 || input_index !== 14'd100) begin
        failures++; $display("FAIL single_hold cyc=%0d occ=%b idx=%0d exp 1/100", i, input_occurred, input_index);
      end
    end
    input_ack = 1'b1; tick(); input_ack = 1'b0; #1;
    checks++;
    if (input_occurred !== 1'b0 || fifo_count !== 4'd0) begin
      failures++; $display("FAIL single_pop occ=%b cnt=%0d exp 0/0", input_occurred, fifo_count);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int r = 0; r < NR; r++) set_idx(r, 10 + r);
    req_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (req_ready !== 4'(1 << (i % NR))) begin
        failures++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", i, req_ready, 4'(1 << (i % NR)));
      end
      tick();
    end
    #1;
    checks++;
    if (fifo_count !== 4'd8 || req_ready !== 4'b0000) begin
      failures++; $display("FAIL rr_full cnt=%0d ready=%b exp 8/0000", fifo_count, req_ready);
    end
    req_valid = '0;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (input_index !== 14'(10 + i % NR)) begin
        failures++; $display("FAIL rr_order pos=%0d got=%0d exp=%0d", i, input_index, 10 + i % NR);
      end
      input_ack = 1'b1; tick(); input_ack = 1'b0;
    end
  endtask

  task automatic test_full_ack();
    do_reset();
    for (int r = 0; r < NR; r++) set_idx(r, 200 + r);
    req_valid = 4'hF;
    repeat (8) tick();
    input_ack = 1'b1; #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++; $display("FAIL full_ack_grant got=%b exp=0000", req_ready);
    end
    tick(); input_ack = 1'b0; #1;
    checks++;
    if (fifo_count !== 4'd7 || req_ready !== m_grant() || req_ready === 4'b0000) begin
      failures++; $display("FAIL full_ack_resume cnt=%0d ready=%b exp 7/%b", fifo_count, req_ready, m_grant());
    end
    tick(); #1;
    checks++;
    if (fifo_count !== 4'd8 || input_index !== 14'd201) begin
      failures++; $display("FAIL full_ack_refill cnt=%0d head=%0d exp 8/201", fifo_count, input_index);
    end
    req_valid = '0;
  endtask

  task automatic test_push_pop();
    do_reset();
    req_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin set_idx(0, 300 + i); tick(); end
    input_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req_valid = 4'($urandom_range(1, 15));
      for (int r = 0; r < NR; r++) set_idx(r, int'($urandom_range(0, 16383)));
      #1;
      checks++;
      if ({input_occurred, input_index, fifo_count, accepted_count} !== exp_out() || fifo_count !== 4'd3) begin
        failures++; $display("FAIL pushpop cyc=%0d got=%h exp=%h cnt=%0d", i,
                             {input_occurred, input_index, fifo_count, accepted_count}, exp_out(), fifo_count);
      end
      tick();
    end
    input_ack = 1'b0; req_valid = '0; #1;
    checks++;
    if (accepted_count !== 16'd13 || fifo_count !== 4'd3) begin
      failures++; $display("FAIL pushpop_total acc=%0d cnt=%0d exp 13/3", accepted_count, fifo_count);
    end
  endtask

  task automatic test_flush();
    do_reset();
    req_valid = 4'hF;
    repeat (5) tick();
    flush = 1'b1; input_ack = 1'b1; #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++; $display("FAIL flush_grant got=%b exp=0000", req_ready);
    end
    tick(); flush = 1'b0; input_ack = 1'b0; req_valid = '0; #1;
    checks++;
    if (fifo_count !== 4'd0 || input_occurred !== 1'b0 || accepted_count !== 16'd5) begin
      failures++; $display("FAIL flush_state cnt=%0d occ=%b acc=%0d exp 0/0/5", fifo_count, input_occurred, accepted_count);
    end
    req_valid = 4'hF; #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++; $display("FAIL flush_rr_kept got=%b exp=0010", req_ready);
    end
    tick(); req_valid = '0;
  endtask

  task automatic test_reset_mid();
    #1;
    checks++;
    if (input_occurred !== 1'b1) begin
      failures++; $display("FAIL mid_precond occ=%b exp=1", input_occurred);
    end
    reset = 1'b1; tick(); reset = 1'b0; #1;
    checks++;
    if ({input_occurred, input_index, fifo_count, accepted_count, req_ready} !== 39'd0) begin
      failures++; $display("FAIL mid_reset occ=%b idx=%0d cnt=%0d acc=%0d ready=%b exp zeros",
                           input_occurred, input_index, fifo_count, accepted_count, req_ready);
    end
    input_ack = 1'b1; tick(); input_ack = 1'b0; #1;
    checks++;
    if (fifo_count !== 4'd0 || input_occurred !== 1'b0) begin
      failures++; $display("FAIL ack_empty cnt=%0d occ=%b exp 0/0", fifo_count, input_occurred);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req_valid = 4'($urandom_range(0, 15));
      for (int r = 0; r < NR; r++) set_idx(r, int'($urandom_range(0, 16383)));
      input_ack = ($urandom_range(0, 2) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      #1;
      checks++;
      if (req_ready !== m_grant() ||
          {input_occurred, input_index, fifo_count, accepted_count} !== exp_out()) begin
        failures++; $display("FAIL random cyc=%0d ready=%b/%b out=%h exp=%h", i, req_ready, m_grant(),
                             {input_occurred, input_index, fifo_count, accepted_count}, exp_out());
      end
      tick();
    end
    req_valid = '0; input_ack = 1'b0; flush = 1'b0;
  endtask

  initial begin
    m_rr = 0; m_acc = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_full_ack();
    test_push_pop();
    test_flush();
    req_valid = 4'b0001; set_idx(0, 77); tick(); req_valid = '0;
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
